muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 98 +++++++++
 tb/tb_muldiv_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit; define MULDIV_MULH_EN to compute MULH/MULHSU/MULHU
module muldiv_unit #(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
    state_t state;
    logic [CW-1:0] count;
    logic [2:0] op_q;
    logic neg_a, neg_b, dz, ovf, acc, sa, sb;
    logic [WIDTH-1:0] x, hi, lo, mag_a, mag_b, mul_lo, mul_hi, quot, rem, fix;
    logic [WIDTH:0] sh, diff;
    assign acc = state == S_IDLE && start;
    assign sa = (op == 3'b001 || op == 3'b010 || (op[2] && !op[0])) && a[WIDTH-1];
    assign sb = (op == 3'b001 || (op[2] && !op[0])) && b[WIDTH-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;
    assign sh = {hi, lo[WIDTH-1]};
    assign diff = sh - {1'b0, x};
`ifdef MULDIV_MULH_EN
    logic [WIDTH:0] sum;
    assign sum = {1'b0, hi} + (lo[0] ? {1'b0, x} : '0);
    assign mul_lo = lo;
    assign mul_hi = (neg_a ^ neg_b) ? ~hi + WIDTH'(lo == '0) : hi;
`else
    assign mul_lo = hi;
    assign mul_hi = '0;
`endif
    assign quot = dz ? '1 : ovf ? MIN : (neg_a ^ neg_b) ? -lo : lo;
    assign rem = ovf ? '0 : neg_a ? -hi : hi;
    assign fix = op_q[2] ? (op_q[1] ? rem : quot) : (op_q[1:0] == 2'b00 ? mul_lo : mul_hi);
    always_ff @(posedge clk) begin
        if (acc) begin
            op_q <= op;
            neg_a <= sa;
            neg_b <= sb;
            dz <= b == '0;
            ovf <= op[2] && !op[0] && a == MIN && b == '1;
            x <= op[2] ? mag_b : mag_a;
            lo <= op[2] ? mag_a : mag_b;
            hi <= '0;
        end else if (state == S_CALC) begin
            if (op_q[2])
                {hi, lo} <= diff[WIDTH] ? {sh[WIDTH-1:0], lo[WIDTH-2:0], 1'b0}
                                        : {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
`ifdef MULDIV_MULH_EN
            else
                {hi, lo} <= {sum, lo[WIDTH-1:1]};
`else
            else begin
                hi <= hi + (lo[0] ? x : '0);
                x <= x << 1;
                lo <= lo >> 1;
            end
`endif
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state <= S_CALC;
                    busy <= 1'b1;
                    count <= CW'(WIDTH);
                end
                S_CALC: begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    result <= fix;
                    done <= 1'b1;
                    busy <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit at WIDTH=32 and WIDTH=16
module tb_muldiv_unit;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
`ifdef MULDIV_MULH_EN
    localparam bit MH = 1'b1;
`else
    localparam bit MH = 1'b0;
`endif
    typedef struct packed {logic [2:0] o; logic [31:0] x, y, e;} vec_t;
    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, start16 = 1'b0;
    logic [2:0] op = '0, op16 = '0;
    logic [31:0] a = '0, b = '0, result;
    logic [15:0] a16 = '0, b16 = '0, result16;
    logic busy, done, busy16, done16;
    int vectors = 0, miscompares = 0;
    always #5 clk = ~clk;
    muldiv_unit dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
                     .busy(busy), .done(done), .result(result));
    muldiv_unit #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
                                     .busy(busy16), .done(done16), .result(result16));
    task automatic run_op(input bit w16, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int poke, output logic [31:0] res, output int lat, output bit busy_ok);
        @(negedge clk);
        if (w16) begin start16 = 1'b1; op16 = o; a16 = x[15:0]; b16 = y[15:0]; end
        else begin start = 1'b1; op = o; a = x; b = y; end
        @(posedge clk); #1;
        start = 1'b0; start16 = 1'b0;
        op = 3'($urandom); op16 = 3'($urandom); a = $urandom; b = $urandom; a16 = 16'($urandom); b16 = 16'($urandom);
        lat = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (!(w16 ? busy16 : busy)) busy_ok = 1'b0;
            if (i == poke) begin
                if (w16) begin start16 = 1'b1; op16 = DIVU; a16 = 16'd5; b16 = 16'd1; end
                else begin start = 1'b1; op = DIVU; a = 32'd5; b = 32'd1; end
            end
            @(posedge clk); #1;
            start = 1'b0; start16 = 1'b0;
            if (w16 ? done16 : done) begin lat = i; break; end
        end
        res = w16 ? {16'h0, result16} : result;
    endtask
    task automatic test_reset;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b exp 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset done got %b exp 0", done); end
        vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset result got %h exp 0", result); end
        vectors++; if (busy16 !== 1'b0) begin miscompares++; $display("FAIL reset busy16 got %b exp 0", busy16); end
        vectors++; if (result16 !== 16'h0) begin miscompares++; $display("FAIL reset result16 got %h exp 0", result16); end
        rst = 1'b0;
    endtask
    task automatic test_mul;
        vec_t v [3] = '{'{MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB},
                        '{MUL, 32'h00010000, 32'h00010003, 32'h00030000},
                        '{MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001}};
        logic [31:0] r;
        int lat;
        bit bok;
        foreach (v[i]) begin
            run_op(1'b0, v[i].o, v[i].x, v[i].y, 0, r, lat, bok);
            vectors++; if (r !== v[i].e) begin miscompares++; $display("FAIL mul[%0d] result got %h exp %h", i, r, v[i].e); end
            vectors++; if (lat !== 33) begin miscompares++; $display("FAIL mul[%0d] latency got %0d exp 33", i, lat); end
            vectors++; if (!bok) begin miscompares++; $display("FAIL mul[%0d] busy dropped early got 0 exp 1", i); end
        end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mul done_width got %b exp 0", done); end
        vectors++; if (result !== 32'h1) begin miscompares++; $display("FAIL mul result_hold got %h exp 00000001", result); end
    endtask
    task automatic test_mulh;
        vec_t v [4] = '{'{MULH, 32'h80000000, 32'h80000000, MH ? 32'h40000000 : 32'h0},
                        '{MULHSU, 32'hFFFFFFFF, 32'd2, MH ? 32'hFFFFFFFF : 32'h0},
                        '{MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, MH ? 32'hFFFFFFFE : 32'h0},
                        '{MULH, 32'hFFFFFFFD, 32'd5, MH ? 32'hFFFFFFFF : 32'h0}};
        logic [31:0] r;
        int lat;
        bit bok;
        foreach (v[i]) begin
            run_op(1'b0, v[i].o, v[i].x, v[i].y, 0, r, lat, bok);
            vectors++; if (r !== v[i].e) begin miscompares++; $display("FAIL mulh[%0d] result got %h exp %h", i, r, v[i].e); end
            vectors++; if (lat !== 33) begin miscompares++; $display("FAIL mulh[%0d] latency got %0d exp 33", i, lat); end
        end
    endtask
    task automatic test_div;
        vec_t v [8] = '{'{DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD},
                        '{REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF},
                        '{DIVU, 32'd100, 32'd7, 32'd14},
                        '{REMU, 32'd100, 32'd7, 32'd2},
                        '{DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD},
                        '{REM, 32'd7, 32'hFFFFFFFE, 32'd1},
                        '{DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF},
                        '{REMU, 32'hFFFFFFFF, 32'd10, 32'd5}};
        logic [31:0] r;
        int lat;
        bit bok;
        foreach (v[i]) begin
            run_op(1'b0, v[i].o, v[i].x, v[i].y, 0, r, lat, bok);
            vectors++; if (r !== v[i].e) begin miscompares++; $display("FAIL div[%0d] result got %h exp %h", i, r, v[i].e); end
            vectors++; if (lat !== 33) begin miscompares++; $display("FAIL div[%0d] latency got %0d exp 33", i, lat); end
        end
    endtask
    task automatic test_special;
        vec_t v [7] = '{'{DIVU, 32'h1234, 32'h0, 32'hFFFFFFFF},
                        '{REM, 32'h1234, 32'h0, 32'h1234},
                        '{DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
                        '{REM, 32'h80000000, 32'hFFFFFFFF, 32'h0},
                        '{DIV, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFF},
                        '{REM, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB},
                        '{REMU, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB}};
        logic [31:0] r;
        int lat;
        bit bok;
        foreach (v[i]) begin
            run_op(1'b0, v[i].o, v[i].x, v[i].y, 0, r, lat, bok);
            vectors++; if (r !== v[i].e) begin miscompares++; $display("FAIL special[%0d] result got %h exp %h", i, r, v[i].e); end
            vectors++; if (lat !== 33) begin miscompares++; $display("FAIL special[%0d] latency got %0d exp 33", i, lat); end
        end
    endtask
    task automatic test_ignore;
        int pokes [2] = '{5, 32};
        logic [31:0] r;
        int lat;
        bit bok;
        foreach (pokes[i]) begin
            run_op(1'b0, MUL, 32'd7, 32'hFFFFFFFD, pokes[i], r, lat, bok);
            vectors++; if (r !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL ignore[%0d] result got %h exp ffffffeb", i, r); end
            vectors++; if (lat !== 33) begin miscompares++; $display("FAIL ignore[%0d] latency got %0d exp 33", i, lat); end
            @(posedge clk); #1;
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ignore[%0d] busy_after got %b exp 0", i, busy); end
        end
    endtask
    task automatic test_back_to_back;
        logic [31:0] r;
        int lat, lat2;
        bit bok;
        run_op(1'b0, DIV, 32'hFFFFFFF9, 32'd2, 0, r, lat, bok);
        vectors++; if (r !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL b2b first got %h exp fffffffd", r); end
        start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b accepted busy got %b exp 1", busy); end
        lat2 = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 10) begin
                vectors++; if (result !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL b2b hold got %h exp fffffffd", result); end
            end
            if (done) begin lat2 = i; break; end
        end
        vectors++; if (lat2 !== 33) begin miscompares++; $display("FAIL b2b latency got %0d exp 33", lat2); end
        vectors++; if (result !== 32'd14) begin miscompares++; $display("FAIL b2b second got %h exp 0000000e", result); end
    endtask
    task automatic test_abort;
        bit saw = 1'b0;
        @(negedge clk);
        start = 1'b1; op = DIV; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort busy got %b exp 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL abort done got %b exp 0", done); end
        vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL abort result got %h exp 0", result); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw = 1'b1;
        end
        vectors++; if (saw !== 1'b0) begin miscompares++; $display("FAIL abort late_activity got %b exp 0", saw); end
    endtask
    task automatic test_width16;
        vec_t v [6] = '{'{MUL, 32'd7, 32'hFFFD, 32'hFFEB},
                        '{DIV, 32'h8000, 32'hFFFF, 32'h8000},
                        '{DIV, 32'hFFF9, 32'd2, 32'hFFFD},
                        '{REM, 32'hFFF9, 32'd2, 32'hFFFF},
                        '{MULHU, 32'hFFFF, 32'hFFFF, MH ? 32'hFFFE : 32'h0},
                        '{DIVU, 32'h1234, 32'h0, 32'hFFFF}};
        logic [31:0] r;
        int lat;
        bit bok;
        foreach (v[i]) begin
            run_op(1'b1, v[i].o, v[i].x, v[i].y, 0, r, lat, bok);
            vectors++; if (r !== v[i].e) begin miscompares++; $display("FAIL w16[%0d] result got %h exp %h", i, r, v[i].e); end
            vectors++; if (lat !== 17) begin miscompares++; $display("FAIL w16[%0d] latency got %0d exp 17", i, lat); end
            vectors++; if (!bok) begin miscompares++; $display("FAIL w16[%0d] busy dropped early got 0 exp 1", i); end
        end
    endtask
    initial begin
        repeat (3) @(posedge clk);
        test_reset;
        test_mul;
        test_mulh;
        test_div;
        test_special;
        test_ignore;
        test_back_to_back;
        test_abort;
        test_width16;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end
endmodule
